// File: rtl/bcd_countdown.sv
// Multi-digit BCD countdown timer with borrow chain, expiry pulse and optional auto-reload.
// Latency: one cycle from LOAD/START/STOP/TICK to Q, BORROW, RUNNING and DONE; ZERO is combinational from Q.
// Backpressure: none; TICK is a single-cycle enable and is consumed or ignored in the cycle it arrives.
//
// Ports:
//   CLK, CLR_N       clock (rising edge), asynchronous active-low reset
//   LOAD, LOAD_VAL   synchronous load of a BCD start value (digit 0 in [3:0]); digits above 9 saturate to 9
//   START, STOP      resume / pause counting
//   TICK             decrement strobe, acted on only while running
//   Q, ZERO          current BCD count and its zero flag
//   BORROW           per-digit borrow-out of the decrement that produced Q
//   RUNNING, DONE    state == RUN, one-cycle pulse on expiry
module bcd_countdown #(
  parameter int DIGITS = 4,
  parameter bit RELOAD = 1'b0
) (
  input  logic                  CLK,
  input  logic                  CLR_N,
  input  logic                  LOAD,
  input  logic [4*DIGITS-1:0]   LOAD_VAL,
  input  logic                  START,
  input  logic                  STOP,
  input  logic                  TICK,
  output logic [4*DIGITS-1:0]   Q,
  output logic                  ZERO,
  output logic [DIGITS-1:0]     BORROW,
  output logic                  RUNNING,
  output logic                  DONE
);

  localparam int W = 4 * DIGITS;
  localparam logic [W-1:0] ONE_VAL = {{(W-1){1'b0}}, 1'b1};

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    RUN     = 2'd1,
    EXPIRED = 2'd2
  } state_t;

  state_t              state_q, state_d;
  logic [W-1:0]        q_q, q_d;
  logic [W-1:0]        reload_q, reload_d;
  logic [DIGITS-1:0]   borrow_q, borrow_d;
  logic                done_q, done_d;

  // BCD decrement of the current count and saturated load value.
  logic [W-1:0]        dec_val;
  logic [DIGITS-1:0]   dec_bo;
  logic [W-1:0]        load_sat;
  logic                bin;
  logic [3:0]          dig;

  always_comb begin
    dec_val  = q_q;
    dec_bo   = '0;
    load_sat = '0;
    bin      = 1'b1;   // digit 0 always receives the borrow that subtracts one
    dig      = '0;
    for (int i = 0; i < DIGITS; i++) begin
      dig = q_q[4*i +: 4];
      if (bin && (dig == 4'd0)) begin
        dec_val[4*i +: 4] = 4'd9;
        dec_bo[i]         = 1'b1;
      end else begin
        dec_val[4*i +: 4] = dig - {3'b000, bin};
      end
      bin = dec_bo[i];
      load_sat[4*i +: 4] = (LOAD_VAL[4*i +: 4] > 4'd9) ? 4'd9 : LOAD_VAL[4*i +: 4];
    end
  end

  // Next-state: LOAD > STOP > START > TICK, exactly one of them acts per cycle.
  always_comb begin
    state_d  = state_q;
    q_d      = q_q;
    reload_d = reload_q;
    borrow_d = '0;
    done_d   = 1'b0;

    if (LOAD) begin
      q_d      = load_sat;
      reload_d = load_sat;
      state_d  = IDLE;
    end else if (STOP) begin
      if (state_q == RUN) begin
        state_d = IDLE;
      end
    end else if (START) begin
      // A zero count cannot start; START while already running is a no-op.
      if ((state_q != RUN) && (q_q != '0)) begin
        state_d = RUN;
      end
    end else if (TICK && (state_q == RUN)) begin
      if (q_q == '0) begin
        // Only reachable if the count was corrupted; never wrap below zero.
        state_d = EXPIRED;
      end else begin
        borrow_d = dec_bo;
        if (q_q == ONE_VAL) begin
          done_d = 1'b1;
          if (RELOAD && (reload_q != '0)) begin
            q_d = reload_q;
          end else begin
            q_d     = '0;
            state_d = EXPIRED;
          end
        end else begin
          q_d = dec_val;
        end
      end
    end
  end

  always_ff @(posedge CLK or negedge CLR_N) begin
    if (!CLR_N) begin
      state_q  <= IDLE;
      q_q      <= '0;
      reload_q <= '0;
      borrow_q <= '0;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      q_q      <= q_d;
      reload_q <= reload_d;
      borrow_q <= borrow_d;
      done_q   <= done_d;
    end
  end

  assign Q       = q_q;
  assign ZERO    = (q_q == '0);
  assign BORROW  = borrow_q;
  assign RUNNING = (state_q == RUN);
  assign DONE    = done_q;

endmodule

// File: tb/tb_bcd_countdown.sv
// Bench for bcd_countdown: one instance without reload, one with reload, shared stimulus.
// Expected responses are queued by the stimulus with the cycle they are due and checked by a monitor.
// Inputs change 1 time unit after the falling edge; outputs are sampled on the falling edge.
module tb_bcd_countdown;

  logic        clk;
  logic        CLR_N;
  logic        LOAD;
  logic [15:0] LOAD_VAL;
  logic        START;
  logic        STOP;
  logic        TICK;

  logic [15:0] q0, q1;
  logic        zero0, zero1;
  logic [3:0]  bor0, bor1;
  logic        run0, run1;
  logic        done0, done1;

  bcd_countdown #(.DIGITS(4), .RELOAD(1'b0)) u_dut0 (
    .CLK(clk), .CLR_N(CLR_N), .LOAD(LOAD), .LOAD_VAL(LOAD_VAL),
    .START(START), .STOP(STOP), .TICK(TICK),
    .Q(q0), .ZERO(zero0), .BORROW(bor0), .RUNNING(run0), .DONE(done0)
  );

  bcd_countdown #(.DIGITS(4), .RELOAD(1'b1)) u_dut1 (
    .CLK(clk), .CLR_N(CLR_N), .LOAD(LOAD), .LOAD_VAL(LOAD_VAL),
    .START(START), .STOP(STOP), .TICK(TICK),
    .Q(q1), .ZERO(zero1), .BORROW(bor1), .RUNNING(run1), .DONE(done1)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct packed {
    logic [31:0] at;
    logic        dut;
    logic [15:0] q;
    logic [3:0]  b;
    logic        run;
    logic        done;
  } exp_t;

  exp_t  exp_q[$];
  string name_q[$];
  int    total = 0;
  int    bad   = 0;

  task automatic push_exp(input int at, input logic dut, input logic [15:0] q,
                          input logic [3:0] b, input logic run, input logic done,
                          input string name);
    exp_t e;
    e.at = at; e.dut = dut; e.q = q; e.b = b; e.run = run; e.done = done;
    exp_q.push_back(e);
    name_q.push_back(name);
  endtask

  // Expectation for the state right after the next rising edge.
  task automatic expect_next(input logic dut, input logic [15:0] q, input logic [3:0] b,
                             input logic run, input logic done, input string name);
    push_exp(cyc + 1, dut, q, b, run, done, name);
  endtask

  task automatic drive(input logic ld, input logic [15:0] lv, input logic st,
                       input logic sp, input logic tk);
    @(negedge clk);
    #1;
    LOAD = ld; LOAD_VAL = lv; START = st; STOP = sp; TICK = tk;
  endtask

  task automatic idle();
    drive(1'b0, 16'h0000, 1'b0, 1'b0, 1'b0);
  endtask

  // Monitor: pops every expectation that is due this cycle and compares.
  always @(negedge clk) begin
    while (exp_q.size() > 0 && int'(exp_q[0].at) <= cyc) begin
      exp_t  e;
      string n;
      logic [15:0] aq;
      logic [3:0]  ab;
      logic        ar, ad, az, ez;
      e = exp_q.pop_front();
      n = name_q.pop_front();
      total++;
      if (int'(e.at) < cyc) begin
        bad++;
        $display("FAIL %s: expectation for cycle %0d not checked (now %0d)", n, e.at, cyc);
      end else begin
        aq = e.dut ? q1 : q0;
        ab = e.dut ? bor1 : bor0;
        ar = e.dut ? run1 : run0;
        ad = e.dut ? done1 : done0;
        az = e.dut ? zero1 : zero0;
        ez = (e.q == 16'h0000);
        if (aq !== e.q || ab !== e.b || ar !== e.run || ad !== e.done || az !== ez) begin
          bad++;
          $display("FAIL %s (dut%0d cyc %0d): got Q=%h BORROW=%b RUN=%b DONE=%b ZERO=%b, want Q=%h BORROW=%b RUN=%b DONE=%b ZERO=%b",
                   n, e.dut, cyc, aq, ab, ar, ad, az, e.q, e.b, e.run, e.done, ez);
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time, total=%0d bad=%0d", total, bad);
    $fatal(1, "watchdog");
  end

  initial begin
    CLR_N = 1'b0; LOAD = 1'b0; LOAD_VAL = '0; START = 1'b0; STOP = 1'b0; TICK = 1'b0;
    @(negedge clk);
    @(negedge clk);
    #1 CLR_N = 1'b1;

    // Reset state on both instances.
    idle();              expect_next(0, 16'h0000, 4'b0000, 0, 0, "reset_dut0");
                         expect_next(1, 16'h0000, 4'b0000, 0, 0, "reset_dut1");

    // START with a zero count is ignored.
    drive(0, 16'h0, 1, 0, 0); expect_next(0, 16'h0000, 4'b0000, 0, 0, "zero_start");
    idle();              expect_next(0, 16'h0000, 4'b0000, 0, 0, "zero_start_hold");

    // Full borrow chain.
    drive(1, 16'h1000, 0, 0, 0); expect_next(0, 16'h1000, 4'b0000, 0, 0, "load_1000");
    drive(0, 16'h0, 1, 0, 0);    expect_next(0, 16'h1000, 4'b0000, 1, 0, "start_1000");
    drive(0, 16'h0, 0, 0, 1);    expect_next(0, 16'h0999, 4'b0111, 1, 0, "borrow_chain");
                                 expect_next(1, 16'h0999, 4'b0111, 1, 0, "borrow_chain_dut1");
    idle();                      expect_next(0, 16'h0999, 4'b0000, 1, 0, "borrow_cleared");
    drive(0, 16'h0, 0, 0, 1);    expect_next(0, 16'h0998, 4'b0000, 1, 0, "dec_0998");
    drive(0, 16'h0, 0, 1, 0);    expect_next(0, 16'h0998, 4'b0000, 0, 0, "stop");
    drive(0, 16'h0, 0, 0, 1);    expect_next(0, 16'h0998, 4'b0000, 0, 0, "tick_in_idle");

    // Expiry without reload.
    drive(1, 16'h0003, 0, 0, 0); expect_next(0, 16'h0003, 4'b0000, 0, 0, "load_3");
    drive(0, 16'h0, 1, 0, 0);    expect_next(0, 16'h0003, 4'b0000, 1, 0, "start_3");
    drive(0, 16'h0, 0, 0, 1);    expect_next(0, 16'h0002, 4'b0000, 1, 0, "exp_tick1");
    idle();                      expect_next(0, 16'h0002, 4'b0000, 1, 0, "exp_gap");
    drive(0, 16'h0, 0, 0, 1);    expect_next(0, 16'h0001, 4'b0000, 1, 0, "exp_tick2");
    drive(0, 16'h0, 0, 0, 1);    expect_next(0, 16'h0000, 4'b0000, 0, 1, "exp_done");
                                 expect_next(1, 16'h0003, 4'b0000, 1, 1, "exp_done_reload");
    idle();                      expect_next(0, 16'h0000, 4'b0000, 0, 0, "exp_done_once");
    drive(0, 16'h0, 1, 0, 0);    expect_next(0, 16'h0000, 4'b0000, 0, 0, "expired_start");
    drive(0, 16'h0, 0, 0, 1);    expect_next(0, 16'h0000, 4'b0000, 0, 0, "expired_tick");

    // Auto-reload sequence.
    drive(1, 16'h0002, 0, 0, 0); expect_next(1, 16'h0002, 4'b0000, 0, 0, "rl_load");
    drive(0, 16'h0, 1, 0, 0);    expect_next(1, 16'h0002, 4'b0000, 1, 0, "rl_start");
    drive(0, 16'h0, 0, 0, 1);    expect_next(1, 16'h0001, 4'b0000, 1, 0, "rl_t1");
    drive(0, 16'h0, 0, 0, 1);    expect_next(1, 16'h0002, 4'b0000, 1, 1, "rl_t2");
                                 expect_next(0, 16'h0000, 4'b0000, 0, 1, "rl_t2_noreload");
    drive(0, 16'h0, 0, 0, 1);    expect_next(1, 16'h0001, 4'b0000, 1, 0, "rl_t3");
    drive(0, 16'h0, 0, 0, 1);    expect_next(1, 16'h0002, 4'b0000, 1, 1, "rl_t4");
    idle();                      expect_next(1, 16'h0002, 4'b0000, 1, 0, "rl_idle");

    // Priority checks.
    drive(1, 16'h0050, 0, 0, 0); expect_next(0, 16'h0050, 4'b0000, 0, 0, "pr_load");
    drive(0, 16'h0, 1, 0, 0);    expect_next(0, 16'h0050, 4'b0000, 1, 0, "pr_start");
    drive(0, 16'h0, 0, 1, 1);    expect_next(0, 16'h0050, 4'b0000, 0, 0, "stop_beats_tick");
    drive(0, 16'h0, 1, 0, 0);    expect_next(0, 16'h0050, 4'b0000, 1, 0, "pr_restart");
    drive(1, 16'h00A7, 0, 0, 1); expect_next(0, 16'h0097, 4'b0000, 0, 0, "load_sat_beats_tick");
    drive(1, 16'h0001, 0, 0, 0); expect_next(0, 16'h0001, 4'b0000, 0, 0, "load_1");
    drive(0, 16'h0, 1, 0, 0);    expect_next(0, 16'h0001, 4'b0000, 1, 0, "start_1");
    drive(1, 16'h0005, 0, 0, 1); expect_next(0, 16'h0005, 4'b0000, 0, 0, "load_beats_expiry");
                                 expect_next(1, 16'h0005, 4'b0000, 0, 0, "load_beats_expiry_dut1");

    // Asynchronous reset while running.
    drive(1, 16'h0375, 0, 0, 0); expect_next(0, 16'h0375, 4'b0000, 0, 0, "ar_load");
    drive(0, 16'h0, 1, 0, 0);    expect_next(0, 16'h0375, 4'b0000, 1, 0, "ar_start");
    idle();                      expect_next(0, 16'h0375, 4'b0000, 1, 0, "ar_running");
    idle();
    @(posedge clk);
    #1 CLR_N = 1'b0;
    // Checked on the falling edge that follows, with no rising edge in between.
    push_exp(cyc, 0, 16'h0000, 4'b0000, 0, 0, "async_reset_dut0");
    push_exp(cyc, 1, 16'h0000, 4'b0000, 0, 0, "async_reset_dut1");
    idle();                      expect_next(0, 16'h0000, 4'b0000, 0, 0, "reset_held");
    @(negedge clk);
    #1 CLR_N = 1'b1;
    drive(1, 16'h0004, 0, 0, 0); expect_next(0, 16'h0004, 4'b0000, 0, 0, "post_reset_load");
    idle();

    for (int i = 0; i < 50 && exp_q.size() > 0; i++) @(negedge clk);
    while (exp_q.size() > 0) begin
      void'(exp_q.pop_front());
      total++;
      bad++;
      $display("FAIL %s: never checked, queue not drained", name_q.pop_front());
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
